keccak_squeeze_ctrl: RTL and testbench
======================================

Name: keccak_squeeze_ctrl

Overview:
- Sequential squeeze-phase controller directly downstream of keccak_output_unit.
- Owns the bytes_squeezed counter that feeds the output unit and captures each combinational chunk the unit produces.
- Trims each chunk to the requested XOF length and buffers it in a 2-entry skid FIFO.
- Presents the data as an AXI-Stream master; handshakes with the core FSM for re-permutation between rate blocks.

Parameters:
- DWIDTH, 256, output bus width in bits (DWIDTH/8 bytes per beat).
- XOF_LEN_WIDTH, 16, width of the requested SHAKE output length in bytes.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  pulse: state ready, begin squeeze (sampled in IDLE only).
- abort_i  in  1  synchronous flush to IDLE.
- keccak_mode_i  in  MODE_SEL_WIDTH  mode, latched on start.
- xof_len_i  in  XOF_LEN_WIDTH  SHAKE output length in bytes, latched on start; ignored for SHA3.
- bytes_squeezed_o  out  BYTE_ABSORB_WIDTH  current counter value, to the output unit.
- chunk_data_i  in  DWIDTH  output-unit data.
- chunk_keep_i  in  DWIDTH/8  output-unit keep; contiguous from bit 0.
- chunk_last_i  in  1  output-unit last (fixed-length modes).
- chunk_bytes_next_i  in  BYTE_ABSORB_WIDTH  output-unit next counter value.
- chunk_perm_needed_i  in  1  output-unit rate-exhausted flag.
- perm_req_o  out  1  one-cycle pulse requesting a permutation.
- perm_done_i  in  1  pulse: permutation complete.
- m_axis_tdata_o  out  DWIDTH  stream data.
- m_axis_tkeep_o  out  DWIDTH/8  stream byte enables.
- m_axis_tlast_o  out  1  final beat.
- m_axis_tvalid_o  out  1  stream valid.
- m_axis_tready_i  in  1  stream ready.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when the last beat has been accepted.

Behaviour:
- Reset: state IDLE; counter, byte total and FIFO cleared; all outputs 0.
- IDLE: on start_i, latch mode and length, clear counter and total, go to SQUEEZE.
  - If the mode is SHAKE and xof_len_i is 0, go straight to DRAIN instead; this emits no beats and pulses done_o on the next cycle.
- SQUEEZE, capture rule: a chunk is captured only when FIFO count < 2 (space flag is registered; no combinational path from tready).
  - n = number of ones in chunk_keep_i; rem = xof_len minus total.
  - For SHAKE, valid bytes = min(n, rem); tkeep = low valid-bytes ones. SHA3 passes keep unchanged.
- SQUEEZE, final-beat test: final when chunk_last_i is set (SHA3), or when valid bytes == rem (SHAKE).
- SQUEEZE, next state after a capture:
  - Final: push with tlast=1, go to DRAIN.
  - Else if chunk_perm_needed_i: push, pulse perm_req_o, clear the counter to 0, go to WAIT_PERM.
  - Else: push, counter <= chunk_bytes_next_i, total += valid bytes.
  - Total is also updated on the permutation path.
- WAIT_PERM: no capture; on perm_done_i return to SQUEEZE. perm_done_i in any other state is ignored.
- DRAIN: no capture; when the FIFO is empty and nothing is in flight, pulse done_o and go to IDLE.
- FIFO and stream:
  - Push and pop in the same cycle are allowed.
  - tvalid = FIFO not empty; pop on tvalid & tready.
  - Data, keep and last are stable while tvalid is high and tready is low (AXI-Stream rule).
- Abort, in any state: FIFO flushed, tvalid low next cycle, state IDLE. No done_o pulse and no perm_req_o pulse.
  - abort_i together with start_i: abort wins.
- Latency: a chunk appears on the stream 1 cycle after capture when the FIFO was empty.
- Asynchronous reset mid-transfer drops all state immediately; tvalid goes low.

Optional Feature:
- Macro KECCAK_SQUEEZE_STATS_EN.
- When defined:
  - Extra output perm_count_o, 16 bits: number of perm_req_o pulses since the last start_i, saturating at 0xFFFF.
  - Extra output beat_count_o, 16 bits: stream beats accepted, saturating.
  - Both counters reset to 0 on rst_ni, on start_i and on abort_i.
- When not defined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- keccak_pkg gains:
  - sqz_state_t enum {SQZ_IDLE, SQZ_SQUEEZE, SQZ_WAIT_PERM, SQZ_DRAIN}.
  - SQZ_FIFO_DEPTH = 2.
  - XOF_LEN_WIDTH default.
- One sub-module, keccak_skid_fifo: 2-entry FIFO with {data, keep, last} entries, registered full/empty flags and the AXI-Stream pop side.

Test Plan:
- SHA3_256 start, tready=1 -> one beat, tkeep=0xFFFFFFFF, tlast=1, no perm_req_o, done_o pulse after acceptance.
- SHA3_512 (rate 576) -> two beats, tlast only on the second, no perm_req_o.
- SHAKE128 (rate 1344), xof_len=200 -> beats with 32,32,32,32,32,8 bytes; perm_req_o after the 8-byte beat; after perm_done_i one 32-byte beat with tlast=1; 7 beats, total 200 bytes.
- SHAKE256, xof_len=5 -> one beat, tkeep=0x1F, tlast=1; xof_len=0 -> no beats, done_o pulse.
- SHAKE128, xof_len=200, tready low for 10 cycles mid-stream -> at most 2 beats buffered, capture stalls, tdata stable; byte order and count unchanged after release.
- abort_i asserted in WAIT_PERM, and rst_ni asserted mid-stream -> tvalid=0, busy_o=0, no done_o pulse; a new start_i works normally.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak/SHA-3 types and constants used by the squeeze controller and its FIFO.
package keccak_pkg;

    localparam int unsigned MODE_SEL_WIDTH        = 3;
    localparam int unsigned BYTE_ABSORB_WIDTH     = 8;
    localparam int unsigned XOF_LEN_WIDTH_DEFAULT = 16;
    localparam int unsigned SQZ_FIFO_DEPTH        = 2;

    typedef enum logic [MODE_SEL_WIDTH-1:0] {
        MODE_SHA3_224 = 3'd0,
        MODE_SHA3_256 = 3'd1,
        MODE_SHA3_384 = 3'd2,
        MODE_SHA3_512 = 3'd3,
        MODE_SHAKE128 = 3'd4,
        MODE_SHAKE256 = 3'd5
    } keccak_mode_t;

    typedef enum logic [1:0] {
        SQZ_IDLE,
        SQZ_SQUEEZE,
        SQZ_WAIT_PERM,
        SQZ_DRAIN
    } sqz_state_t;

    function automatic logic is_shake(input logic [MODE_SEL_WIDTH-1:0] mode);
        return (mode == MODE_SHAKE128) || (mode == MODE_SHAKE256);
    endfunction

endpackage

// File: rtl/keccak_skid_fifo.sv
// Two-entry {data, keep, last} FIFO with registered full/empty flags driving an AXI-Stream master.
module keccak_skid_fifo
    import keccak_pkg::*;
#(
    parameter int unsigned DWIDTH = 256
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic                                  push_i,
    input  logic [DWIDTH-1:0]                     push_data_i,
    input  logic [DWIDTH/8-1:0]                   push_keep_i,
    input  logic                                  push_last_i,
    output logic                                  full_o,
    output logic [$clog2(SQZ_FIFO_DEPTH+1)-1:0]   level_o,
    output logic [DWIDTH-1:0]                     m_axis_tdata_o,
    output logic [DWIDTH/8-1:0]                   m_axis_tkeep_o,
    output logic                                  m_axis_tlast_o,
    output logic                                  m_axis_tvalid_o,
    input  logic                                  m_axis_tready_i
);

    localparam int unsigned AW = (SQZ_FIFO_DEPTH > 1) ? $clog2(SQZ_FIFO_DEPTH) : 1;
    localparam int unsigned LW = $clog2(SQZ_FIFO_DEPTH + 1);

    logic [DWIDTH-1:0]   data_q [SQZ_FIFO_DEPTH];
    logic [DWIDTH/8-1:0] keep_q [SQZ_FIFO_DEPTH];
    logic                last_q [SQZ_FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]       level_q, level_d;
    logic                full_q, empty_q, push, pop;

    assign push    = push_i && !full_q;
    assign pop     = !empty_q && m_axis_tready_i;
    assign level_d = level_q + LW'(push) - LW'(pop);

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(SQZ_FIFO_DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < SQZ_FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                keep_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= push_data_i;
                keep_q[wr_ptr_q] <= push_keep_i;
                last_q[wr_ptr_q] <= push_last_i;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            level_q <= level_d;
            full_q  <= (level_d == LW'(SQZ_FIFO_DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    assign full_o          = full_q;
    assign level_o         = level_q;
    assign m_axis_tdata_o  = data_q[rd_ptr_q];
    assign m_axis_tkeep_o  = keep_q[rd_ptr_q];
    assign m_axis_tlast_o  = last_q[rd_ptr_q];
    assign m_axis_tvalid_o = !empty_q;

endmodule

// File: rtl/keccak_squeeze_ctrl.sv
// Squeeze-phase controller: drives the output-unit byte counter, trims chunks to the XOF length
// and streams them out over AXI-Stream. Define KECCAK_SQUEEZE_STATS_EN for perm/beat counters.
module keccak_squeeze_ctrl
    import keccak_pkg::*;
#(
    parameter int unsigned DWIDTH        = 256,
    parameter int unsigned XOF_LEN_WIDTH = XOF_LEN_WIDTH_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [MODE_SEL_WIDTH-1:0]    keccak_mode_i,
    input  logic [XOF_LEN_WIDTH-1:0]     xof_len_i,
    output logic [BYTE_ABSORB_WIDTH-1:0] bytes_squeezed_o,
    input  logic [DWIDTH-1:0]            chunk_data_i,
    input  logic [DWIDTH/8-1:0]          chunk_keep_i,
    input  logic                         chunk_last_i,
    input  logic [BYTE_ABSORB_WIDTH-1:0] chunk_bytes_next_i,
    input  logic                         chunk_perm_needed_i,
    output logic                         perm_req_o,
    input  logic                         perm_done_i,
    output logic [DWIDTH-1:0]            m_axis_tdata_o,
    output logic [DWIDTH/8-1:0]          m_axis_tkeep_o,
    output logic                         m_axis_tlast_o,
    output logic                         m_axis_tvalid_o,
    input  logic                         m_axis_tready_i,
    output logic                         busy_o,
    output logic                         done_o
`ifdef KECCAK_SQUEEZE_STATS_EN
    ,
    output logic [15:0]                  perm_count_o,
    output logic [15:0]                  beat_count_o
`endif
);

    localparam int unsigned KW = DWIDTH / 8;
    localparam int unsigned CW = $clog2(KW + 1);
    localparam int unsigned LW = $clog2(SQZ_FIFO_DEPTH + 1);

    sqz_state_t                   state_q;
    logic [MODE_SEL_WIDTH-1:0]    mode_q;
    logic [XOF_LEN_WIDTH-1:0]     xof_len_q, total_q, rem;
    logic [BYTE_ABSORB_WIDTH-1:0] cnt_q;
    logic                         perm_req_q, done_q;
    logic [CW-1:0]                n_bytes, valid_bytes;
    logic [KW-1:0]                trim_keep;
    logic                         shake, is_final, capture, fifo_full, fifo_pop, drain_done;
    logic [LW-1:0]                fifo_level;

    always_comb begin
        n_bytes = '0;
        for (int unsigned i = 0; i < KW; i++) begin
            n_bytes = n_bytes + CW'(chunk_keep_i[i]);
        end
    end

    assign shake = is_shake(mode_q);
    assign rem   = xof_len_q - total_q;

    // SHAKE clips the chunk to the bytes still owed; SHA3 digests pass through untouched.
    always_comb begin
        valid_bytes = n_bytes;
        if (shake && (rem < XOF_LEN_WIDTH'(n_bytes))) begin
            valid_bytes = CW'(rem);
        end
        trim_keep = chunk_keep_i;
        if (shake) begin
            for (int unsigned i = 0; i < KW; i++) begin
                trim_keep[i] = (CW'(i) < valid_bytes);
            end
        end
    end

    assign is_final   = shake ? (XOF_LEN_WIDTH'(valid_bytes) == rem) : chunk_last_i;
    assign capture    = (state_q == SQZ_SQUEEZE) && !fifo_full && !abort_i;
    assign fifo_pop   = m_axis_tvalid_o && m_axis_tready_i;
    assign drain_done = (fifo_level == '0) || ((fifo_level == LW'(1)) && fifo_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= SQZ_IDLE;
            mode_q     <= '0;
            xof_len_q  <= '0;
            total_q    <= '0;
            cnt_q      <= '0;
            perm_req_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            perm_req_q <= 1'b0;
            done_q     <= 1'b0;
            if (abort_i) begin
                state_q <= SQZ_IDLE;
            end else begin
                case (state_q)
                    SQZ_IDLE: begin
                        if (start_i) begin
                            mode_q    <= keccak_mode_i;
                            xof_len_q <= xof_len_i;
                            total_q   <= '0;
                            cnt_q     <= '0;
                            state_q   <= (is_shake(keccak_mode_i) && (xof_len_i == '0))
                                         ? SQZ_DRAIN : SQZ_SQUEEZE;
                        end
                    end
                    SQZ_SQUEEZE: begin
                        if (capture) begin
                            total_q <= total_q + XOF_LEN_WIDTH'(valid_bytes);
                            if (is_final) begin
                                state_q <= SQZ_DRAIN;
                            end else if (chunk_perm_needed_i) begin
                                perm_req_q <= 1'b1;
                                cnt_q      <= '0;
                                state_q    <= SQZ_WAIT_PERM;
                            end else begin
                                cnt_q <= chunk_bytes_next_i;
                            end
                        end
                    end
                    SQZ_WAIT_PERM: begin
                        if (perm_done_i) begin
                            state_q <= SQZ_SQUEEZE;
                        end
                    end
                    SQZ_DRAIN: begin
                        if (drain_done) begin
                            done_q  <= 1'b1;
                            state_q <= SQZ_IDLE;
                        end
                    end
                    default: state_q <= SQZ_IDLE;
                endcase
            end
        end
    end

    keccak_skid_fifo #(
        .DWIDTH (DWIDTH)
    ) u_fifo (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (abort_i),
        .push_i          (capture),
        .push_data_i     (chunk_data_i),
        .push_keep_i     (trim_keep),
        .push_last_i     (is_final),
        .full_o          (fifo_full),
        .level_o         (fifo_level),
        .m_axis_tdata_o  (m_axis_tdata_o),
        .m_axis_tkeep_o  (m_axis_tkeep_o),
        .m_axis_tlast_o  (m_axis_tlast_o),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tready_i (m_axis_tready_i)
    );

    assign bytes_squeezed_o = cnt_q;
    assign perm_req_o       = perm_req_q;
    assign done_o           = done_q;
    assign busy_o           = (state_q != SQZ_IDLE);

`ifdef KECCAK_SQUEEZE_STATS_EN
    logic start_acc;
    assign start_acc = start_i && (state_q == SQZ_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perm_count_o <= '0;
            beat_count_o <= '0;
        end else if (abort_i || start_acc) begin
            perm_count_o <= '0;
            beat_count_o <= '0;
        end else begin
            if (perm_req_q && (perm_count_o != '1)) begin
                perm_count_o <= perm_count_o + 16'd1;
            end
            if (fifo_pop && (beat_count_o != '1)) begin
                beat_count_o <= beat_count_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_keccak_squeeze_ctrl.sv
// Directed bench for keccak_squeeze_ctrl with a behavioural output-unit model and permutation responder.
module tb_keccak_squeeze_ctrl;
    import keccak_pkg::*;

    localparam int unsigned DW  = 256;
    localparam int unsigned KW  = DW / 8;
    localparam int          KWI = 32;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         start = 1'b0;
    logic                         abort = 1'b0;
    logic                         perm_done = 1'b0;
    logic                         tready = 1'b0;
    logic [MODE_SEL_WIDTH-1:0]    mode = '0;
    logic [15:0]                  xof_len = '0;
    logic [BYTE_ABSORB_WIDTH-1:0] bytes_sq, ou_next;
    logic [DW-1:0]                ou_data, tdata;
    logic [KW-1:0]                ou_keep, tkeep;
    logic                         ou_last, ou_perm, perm_req, tlast, tvalid, busy, done;

    always #5 clk = ~clk;

    keccak_squeeze_ctrl #(
        .DWIDTH        (DW),
        .XOF_LEN_WIDTH (16)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .start_i             (start),
        .abort_i             (abort),
        .keccak_mode_i       (mode),
        .xof_len_i           (xof_len),
        .bytes_squeezed_o    (bytes_sq),
        .chunk_data_i        (ou_data),
        .chunk_keep_i        (ou_keep),
        .chunk_last_i        (ou_last),
        .chunk_bytes_next_i  (ou_next),
        .chunk_perm_needed_i (ou_perm),
        .perm_req_o          (perm_req),
        .perm_done_i         (perm_done),
        .m_axis_tdata_o      (tdata),
        .m_axis_tkeep_o      (tkeep),
        .m_axis_tlast_o      (tlast),
        .m_axis_tvalid_o     (tvalid),
        .m_axis_tready_i     (tready),
        .busy_o              (busy),
        .done_o              (done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rate_of(input logic [MODE_SEL_WIDTH-1:0] m);
        case (m)
            MODE_SHA3_224: return 144;
            MODE_SHA3_256: return 136;
            MODE_SHA3_384: return 104;
            MODE_SHA3_512: return 72;
            MODE_SHAKE128: return 168;
            default:       return 136;
        endcase
    endfunction

    function automatic int digest_of(input logic [MODE_SEL_WIDTH-1:0] m);
        case (m)
            MODE_SHA3_224: return 28;
            MODE_SHA3_256: return 32;
            MODE_SHA3_384: return 48;
            MODE_SHA3_512: return 64;
            default:       return 0;
        endcase
    endfunction

    // Output-unit model: byte value encodes rate offset plus 64 per permutation block.
    int ou_rate = 136, ou_digest = 32, ou_shake = 0, blk = 0;
    always_comb begin
        int bs, n;
        bs = int'(bytes_sq);
        n  = (ou_shake != 0) ? (ou_rate - bs) : (ou_digest - bs);
        if (n < 0) n = 0;
        if (n > KWI) n = KWI;
        ou_last = (ou_shake == 0) && (bs + n >= ou_digest);
        ou_perm = (ou_shake != 0) && (bs + n == ou_rate);
        ou_next = BYTE_ABSORB_WIDTH'(bs + n);
        ou_keep = '0;
        ou_data = '0;
        for (int i = 0; i < KWI; i++) begin
            ou_keep[i]        = (i < n);
            ou_data[8*i +: 8] = 8'(bs + i + 64 * blk);
        end
    end

    int resp_delay = 3;
    always @(negedge clk) begin
        if (perm_req) begin
            repeat (resp_delay) @(posedge clk);
            #1 perm_done = 1'b1;
            blk++;
            @(posedge clk);
            #1 perm_done = 1'b0;
        end
    end

    int            beats = 0, bytes_seen = 0, perms = 0, dones = 0, lasts = 0;
    int            exp_total_bytes = 0, cur_rate = 136;
    logic [KW-1:0] last_keep = '0;
    logic          stall_prev = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [KW-1:0] prev_keep = '0;

    always @(negedge clk) begin
        if (perm_req) perms++;
        if (done) dones++;
        if (stall_prev) begin
            check("hold_stable",
                  64'({tvalid, (tdata == prev_data) && (tkeep == prev_keep) && (tlast == prev_last)}),
                  64'd3);
        end
        stall_prev = tvalid && !tready;
        prev_data  = tdata;
        prev_keep  = tkeep;
        prev_last  = tlast;
        if (tvalid && tready) begin
            int   nb, g;
            logic ok;
            nb = 0;
            ok = 1'b1;
            for (int i = 0; i < KWI; i++) begin
                if (tkeep[i]) begin
                    nb++;
                    g = bytes_seen + i;
                    if (tdata[8*i +: 8] != 8'((g % cur_rate) + 64 * (g / cur_rate))) ok = 1'b0;
                end
            end
            check("beat_data", 64'(ok), 64'd1);
            bytes_seen += nb;
            beats++;
            check("beat_last", 64'(tlast), 64'(bytes_seen == exp_total_bytes));
            if (tlast) begin
                lasts++;
                last_keep = tkeep;
            end
        end
    end

    task automatic start_txn(input logic [MODE_SEL_WIDTH-1:0] m, input int xl);
        ou_shake        = is_shake(m) ? 1 : 0;
        ou_rate         = rate_of(m);
        ou_digest       = digest_of(m);
        cur_rate        = ou_rate;
        exp_total_bytes = is_shake(m) ? xl : ou_digest;
        beats = 0; bytes_seen = 0; perms = 0; dones = 0; lasts = 0; last_keep = '0; blk = 0;
        @(posedge clk);
        #1 start = 1'b1; mode = m; xof_len = 16'(xl);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int rmode);
        bit                           stalled = 1'b0;
        int                           cyc = 0;
        logic [BYTE_ABSORB_WIDTH-1:0] bs_a;
        while (dones == 0 && cyc < 1000) begin
            if (rmode == 1 && !stalled && beats >= 2) begin
                tready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bs_a = bytes_sq;
                repeat (7) @(posedge clk);
                #1;
                check("stall_capture", 64'(bytes_sq), 64'(bs_a));
                check("stall_valid", 64'(tvalid), 64'd1);
                stalled = 1'b1;
            end
            tready = (rmode == 2) ? cyc[0] : 1'b1;
            @(posedge clk);
            #1 cyc++;
        end
        check("done_seen", 64'(dones != 0), 64'd1);
        tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [MODE_SEL_WIDTH-1:0] mode;
        int                        xof;
        int                        ready_mode;
        int                        exp_beats;
        int                        exp_bytes;
        int                        exp_perms;
        logic [KW-1:0]             exp_last_keep;
    } vec_t;

    vec_t vecs[10];

    task automatic compare_txn(input vec_t v);
        check("beats", 64'(beats), 64'(v.exp_beats));
        check("bytes", 64'(bytes_seen), 64'(v.exp_bytes));
        check("perm_reqs", 64'(perms), 64'(v.exp_perms));
        check("last_keep", 64'(last_keep), 64'(v.exp_last_keep));
        check("tlast_count", 64'(lasts), 64'(v.exp_beats > 0));
        check("done_once", 64'(dones), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wait_cyc;

        vecs[0] = '{MODE_SHA3_256, 0,   0, 1,  32,  0, 32'hFFFF_FFFF};
        vecs[1] = '{MODE_SHA3_512, 0,   0, 2,  64,  0, 32'hFFFF_FFFF};
        vecs[2] = '{MODE_SHA3_224, 0,   2, 1,  28,  0, 32'h0FFF_FFFF};
        vecs[3] = '{MODE_SHA3_384, 0,   2, 2,  48,  0, 32'h0000_FFFF};
        vecs[4] = '{MODE_SHAKE128, 200, 0, 7,  200, 1, 32'hFFFF_FFFF};
        vecs[5] = '{MODE_SHAKE256, 5,   0, 1,  5,   0, 32'h0000_001F};
        vecs[6] = '{MODE_SHAKE256, 0,   0, 0,  0,   0, 32'h0000_0000};
        vecs[7] = '{MODE_SHAKE128, 168, 2, 6,  168, 0, 32'h0000_00FF};
        vecs[8] = '{MODE_SHAKE256, 300, 2, 11, 300, 2, 32'h0FFF_FFFF};
        vecs[9] = '{MODE_SHAKE128, 200, 1, 7,  200, 1, 32'hFFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_perm_req", 64'(perm_req), 64'd0);
        check("rst_counter", 64'(bytes_sq), 64'd0);
        check("rst_stream", 64'({tdata == '0, tkeep == '0, tlast}), 64'd6);
        rst_n = 1'b1;

        // First-beat latency: visible one cycle after the capture cycle.
        tready = 1'b1;
        start_txn(MODE_SHA3_256, 0);
        check("lat_busy", 64'(busy), 64'd1);
        check("lat_pre_valid", 64'(tvalid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 64'(tvalid), 64'd1);
        check("lat_keep", 64'(tkeep), 64'hFFFF_FFFF);
        check("lat_last", 64'(tlast), 64'd1);
        wait_done(0);
        compare_txn(vecs[0]);

        for (int unsigned k = 0; k < 10; k++) begin
            tready = 1'b1;
            start_txn(vecs[k].mode, vecs[k].xof);
            wait_done(vecs[k].ready_mode);
            compare_txn(vecs[k]);
        end

        // Abort while waiting on a slow permutation.
        resp_delay = 20;
        tready     = 1'b1;
        start_txn(MODE_SHAKE128, 200);
        wait_cyc = 0;
        while (perms == 0 && wait_cyc < 200) begin
            @(posedge clk);
            #1 wait_cyc++;
        end
        check("abort_perm_seen", 64'(perms), 64'd1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_tvalid", 64'(tvalid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_done", 64'(dones), 64'd0);
        check("abort_no_perm", 64'(perms), 64'd1);
        check("abort_late_perm_done", 64'({busy, tvalid}), 64'd0);
        resp_delay = 3;

        // Abort and start together: abort wins.
        @(posedge clk);
        #1 start = 1'b1; abort = 1'b1; mode = MODE_SHA3_256;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        check("abort_start_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("abort_start_tvalid", 64'(tvalid), 64'd0);

        // Asynchronous reset mid-stream.
        start_txn(MODE_SHAKE128, 200);
        wait_cyc = 0;
        while (beats < 3 && wait_cyc < 200) begin
            @(posedge clk);
            #1 wait_cyc++;
        end
        check("rst_mid_beats", 64'(beats >= 3), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tvalid", 64'(tvalid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_no_done", 64'(dones), 64'd0);

        start_txn(vecs[4].mode, vecs[4].xof);
        wait_done(0);
        compare_txn(vecs[4]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
